// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: ALU operation codes, opcodes and the
// decoded control bundle carried from ID into EX.
package mips_pipe_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_ADDU = 4'b1000;
    localparam logic [3:0] ALU_SUBU = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_LUI  = 4'b1110;
    localparam logic [3:0] ALU_FUNC = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic [1:0] RegDst;
        logic       ALUSrc;
        logic       MemToReg;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       Branch;
        logic       Jump;
        logic       SignExtend;
        logic       UseShmt;
        logic [3:0] ALUOp;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check: a load in EX whose destination is a
// source register actually read by the instruction sitting in ID.
module load_use_detect
    import mips_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  exValid,
    input  logic                  exMemRead,
    input  logic [REG_ADDR_W-1:0] exRt,
    input  logic                  idJump,
    input  logic                  idUseShmt,
    input  logic                  idMemWrite,
    input  logic                  idALUSrc,
    input  logic [3:0]            idALUOp,
    input  logic [REG_ADDR_W-1:0] idRs,
    input  logic [REG_ADDR_W-1:0] idRt,
    output logic                  stall
);

    logic usesRs;
    logic usesRt;

    // Shifts by shamt and LUI never read rs; stores always read rt as data.
    assign usesRs = !idJump && !(idUseShmt && !idMemWrite) && (idALUOp != ALU_LUI);
    assign usesRt = !idALUSrc || idMemWrite;

    assign stall = exValid && exMemRead && (exRt != '0) &&
                   ((usesRs && (exRt == idRs)) || (usesRt && (exRt == idRt)));

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall and flush bubble insertion.
// Optional stall/flush event counters are built when HAZ_PERF_COUNT_EN is defined.
module id_ex_hazard_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  CLK,
    input  logic                  Reset_L,
    input  logic [1:0]            id_RegDst,
    input  logic                  id_ALUSrc,
    input  logic                  id_MemToReg,
    input  logic                  id_RegWrite,
    input  logic                  id_MemRead,
    input  logic                  id_MemWrite,
    input  logic                  id_Branch,
    input  logic                  id_Jump,
    input  logic                  id_SignExtend,
    input  logic                  id_UseShmt,
    input  logic [3:0]            id_ALUOp,
    input  logic [DATA_W-1:0]     id_ReadData1,
    input  logic [DATA_W-1:0]     id_ReadData2,
    input  logic [DATA_W-1:0]     id_Imm,
    input  logic [DATA_W-1:0]     id_PCPlus4,
    input  logic [REG_ADDR_W-1:0] id_Rs,
    input  logic [REG_ADDR_W-1:0] id_Rt,
    input  logic [REG_ADDR_W-1:0] id_Rd,
    input  logic [REG_ADDR_W-1:0] id_Shamt,
    input  logic                  flush,
    output logic [1:0]            ex_RegDst,
    output logic                  ex_ALUSrc,
    output logic                  ex_MemToReg,
    output logic                  ex_RegWrite,
    output logic                  ex_MemRead,
    output logic                  ex_MemWrite,
    output logic                  ex_Branch,
    output logic                  ex_Jump,
    output logic                  ex_SignExtend,
    output logic                  ex_UseShmt,
    output logic [3:0]            ex_ALUOp,
    output logic [DATA_W-1:0]     ex_ReadData1,
    output logic [DATA_W-1:0]     ex_ReadData2,
    output logic [DATA_W-1:0]     ex_Imm,
    output logic [DATA_W-1:0]     ex_PCPlus4,
    output logic [REG_ADDR_W-1:0] ex_Rs,
    output logic [REG_ADDR_W-1:0] ex_Rt,
    output logic [REG_ADDR_W-1:0] ex_Rd,
    output logic [REG_ADDR_W-1:0] ex_Shamt,
    output logic                  ex_Valid,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  stall
`ifdef HAZ_PERF_COUNT_EN
    ,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
`endif
);

    ctrl_t idCtrl;
    ctrl_t exCtrl;

    assign idCtrl = '{RegDst:     id_RegDst,
                      ALUSrc:     id_ALUSrc,
                      MemToReg:   id_MemToReg,
                      RegWrite:   id_RegWrite,
                      MemRead:    id_MemRead,
                      MemWrite:   id_MemWrite,
                      Branch:     id_Branch,
                      Jump:       id_Jump,
                      SignExtend: id_SignExtend,
                      UseShmt:    id_UseShmt,
                      ALUOp:      id_ALUOp};

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_loadUse (
        .exValid    (ex_Valid),
        .exMemRead  (exCtrl.MemRead),
        .exRt       (ex_Rt),
        .idJump     (id_Jump),
        .idUseShmt  (id_UseShmt),
        .idMemWrite (id_MemWrite),
        .idALUSrc   (id_ALUSrc),
        .idALUOp    (id_ALUOp),
        .idRs       (id_Rs),
        .idRt       (id_Rt),
        .stall      (stall)
    );

    assign PCWrite   = !stall && Reset_L;
    assign IFIDWrite = !stall && Reset_L;

    // Flush and stall both write a bubble; data is zeroed so a bubble is fully deterministic.
    always_ff @(posedge CLK) begin
        if (!Reset_L || flush || stall) begin
            exCtrl       <= CTRL_BUBBLE;
            ex_ReadData1 <= '0;
            ex_ReadData2 <= '0;
            ex_Imm       <= '0;
            ex_PCPlus4   <= '0;
            ex_Rs        <= '0;
            ex_Rt        <= '0;
            ex_Rd        <= '0;
            ex_Shamt     <= '0;
            ex_Valid     <= 1'b0;
        end else begin
            exCtrl       <= idCtrl;
            ex_ReadData1 <= id_ReadData1;
            ex_ReadData2 <= id_ReadData2;
            ex_Imm       <= id_Imm;
            ex_PCPlus4   <= id_PCPlus4;
            ex_Rs        <= id_Rs;
            ex_Rt        <= id_Rt;
            ex_Rd        <= id_Rd;
            ex_Shamt     <= id_Shamt;
            ex_Valid     <= 1'b1;
        end
    end

    assign ex_RegDst     = exCtrl.RegDst;
    assign ex_ALUSrc     = exCtrl.ALUSrc;
    assign ex_MemToReg   = exCtrl.MemToReg;
    assign ex_RegWrite   = exCtrl.RegWrite;
    assign ex_MemRead    = exCtrl.MemRead;
    assign ex_MemWrite   = exCtrl.MemWrite;
    assign ex_Branch     = exCtrl.Branch;
    assign ex_Jump       = exCtrl.Jump;
    assign ex_SignExtend = exCtrl.SignExtend;
    assign ex_UseShmt    = exCtrl.UseShmt;
    assign ex_ALUOp      = exCtrl.ALUOp;

`ifdef HAZ_PERF_COUNT_EN
    // A stall coinciding with a flush is counted as a flush only, since flush wins.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (flush && (flush_count != 32'hFFFF_FFFF))
                flush_count <= flush_count + 32'd1;
            if (!flush && stall && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg: random and directed ID streams checked
// against a source-register/hazard reference model; counters checked when HAZ_PERF_COUNT_EN is set.
module tb_id_ex_hazard_reg;

    typedef struct packed {
        logic [1:0] RegDst;
        logic       ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Jump, SignExtend, UseShmt;
        logic [3:0] ALUOp;
    } tbCtrl_t;

    typedef struct packed {
        logic [31:0] rd1, rd2, imm, pc4;
        logic [4:0]  rs, rt, rd, sh;
    } tbData_t;

    typedef struct packed {
        tbCtrl_t c;
        tbData_t d;
    } instr_t;

    typedef struct packed {
        instr_t i;
        logic   valid;
        logic   chkData;
    } exp_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        Reset_L;
    logic        flush;
    instr_t      cur;
    logic [1:0]  ex_RegDst;
    logic        ex_ALUSrc, ex_MemToReg, ex_RegWrite, ex_MemRead, ex_MemWrite;
    logic        ex_Branch, ex_Jump, ex_SignExtend, ex_UseShmt, ex_Valid;
    logic [3:0]  ex_ALUOp;
    logic [31:0] ex_ReadData1, ex_ReadData2, ex_Imm, ex_PCPlus4;
    logic [4:0]  ex_Rs, ex_Rt, ex_Rd, ex_Shamt;
    logic        PCWrite, IFIDWrite, stall;
`ifdef HAZ_PERF_COUNT_EN
    logic [31:0] stall_count, flush_count;
`endif

    id_ex_hazard_reg #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .CLK(CLK), .Reset_L(Reset_L),
        .id_RegDst(cur.c.RegDst), .id_ALUSrc(cur.c.ALUSrc), .id_MemToReg(cur.c.MemToReg),
        .id_RegWrite(cur.c.RegWrite), .id_MemRead(cur.c.MemRead), .id_MemWrite(cur.c.MemWrite),
        .id_Branch(cur.c.Branch), .id_Jump(cur.c.Jump), .id_SignExtend(cur.c.SignExtend),
        .id_UseShmt(cur.c.UseShmt), .id_ALUOp(cur.c.ALUOp),
        .id_ReadData1(cur.d.rd1), .id_ReadData2(cur.d.rd2), .id_Imm(cur.d.imm), .id_PCPlus4(cur.d.pc4),
        .id_Rs(cur.d.rs), .id_Rt(cur.d.rt), .id_Rd(cur.d.rd), .id_Shamt(cur.d.sh),
        .flush(flush),
        .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemToReg(ex_MemToReg),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .ex_SignExtend(ex_SignExtend),
        .ex_UseShmt(ex_UseShmt), .ex_ALUOp(ex_ALUOp),
        .ex_ReadData1(ex_ReadData1), .ex_ReadData2(ex_ReadData2), .ex_Imm(ex_Imm), .ex_PCPlus4(ex_PCPlus4),
        .ex_Rs(ex_Rs), .ex_Rt(ex_Rt), .ex_Rd(ex_Rd), .ex_Shamt(ex_Shamt),
        .ex_Valid(ex_Valid), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .stall(stall)
`ifdef HAZ_PERF_COUNT_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    int     nChecks = 0;
    int     nFails  = 0;
    exp_t   sbq[$];
    exp_t   modelEx;
    logic   modelKnown = 1'b0;
    logic   lastStall  = 1'b0;
    int     mStallCnt  = 0;
    int     mFlushCnt  = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rule: the set of registers an instruction reads, then ask whether
    // the pending load's destination is among them.
    function automatic logic hazard(input exp_t ex, input instr_t n);
        logic [4:0] srcs[$];
        if (!n.c.Jump && !(n.c.UseShmt && !n.c.MemWrite) && n.c.ALUOp != 4'b1110)
            srcs.push_back(n.d.rs);
        if (!n.c.ALUSrc || n.c.MemWrite)
            srcs.push_back(n.d.rt);
        if (!(ex.valid && ex.i.c.MemRead) || ex.i.d.rt == 5'd0)
            return 1'b0;
        foreach (srcs[k])
            if (srcs[k] == ex.i.d.rt) return 1'b1;
        return 1'b0;
    endfunction

    function automatic instr_t randInstr();
        instr_t      r;
        logic [31:0] w;
        w     = $urandom;
        r.c   = w[14:0];
        r.d.rd1 = $urandom; r.d.rd2 = $urandom; r.d.imm = $urandom; r.d.pc4 = $urandom;
        r.d.rs  = 5'($urandom_range(0, 3));
        r.d.rt  = 5'($urandom_range(0, 3));
        r.d.rd  = 5'($urandom_range(0, 31));
        r.d.sh  = 5'($urandom_range(0, 31));
        return r;
    endfunction

    function automatic instr_t mkLw(input logic [4:0] rt, input logic [4:0] rs);
        instr_t r = '0;
        r.c.ALUSrc = 1; r.c.MemToReg = 1; r.c.RegWrite = 1; r.c.MemRead = 1;
        r.c.SignExtend = 1; r.c.ALUOp = 4'b0010;
        r.d.rs = rs; r.d.rt = rt; r.d.rd1 = 32'h100; r.d.pc4 = 32'h40;
        return r;
    endfunction

    function automatic instr_t mkAdd(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [31:0] a, input logic [31:0] b);
        instr_t r = '0;
        r.c.RegDst = 2'b01; r.c.RegWrite = 1; r.c.ALUOp = 4'b1111;
        r.d.rs = rs; r.d.rt = rt; r.d.rd = rd; r.d.rd1 = a; r.d.rd2 = b; r.d.pc4 = 32'h44;
        return r;
    endfunction

    // rs is set equal to rt so only the LUI exclusion can prevent a stall.
    function automatic instr_t mkLui(input logic [4:0] rt);
        instr_t r = '0;
        r.c.ALUSrc = 1; r.c.RegWrite = 1; r.c.ALUOp = 4'b1110;
        r.d.rs = rt; r.d.rt = rt; r.d.imm = 32'h1234;
        return r;
    endfunction

    function automatic instr_t mkSll(input logic [4:0] rd, input logic [4:0] rt, input logic [4:0] sh);
        instr_t r = '0;
        r.c.RegDst = 2'b01; r.c.RegWrite = 1; r.c.UseShmt = 1; r.c.ALUOp = 4'b1111;
        r.d.rt = rt; r.d.rd = rd; r.d.sh = sh;
        return r;
    endfunction

    task automatic step(input instr_t ins, input logic fl, input logic rstL, input int expS);
        exp_t nxt;
        logic h;
        @(negedge CLK);
        cur = ins; flush = fl; Reset_L = rstL;
        #1;
        h = hazard(modelEx, ins);
        if (modelKnown) begin
            chk("stall", stall, h);
            chk("PCWrite", PCWrite, !h && rstL);
            chk("IFIDWrite", IFIDWrite, !h && rstL);
        end else begin
            chk("PCWrite_rst", PCWrite, 1'b0);
        end
        if (expS >= 0) chk("stall_dir", stall, expS[0]);
        nxt = '0;
        if (!rstL) begin
            nxt.chkData = 1'b1;
            mStallCnt = 0; mFlushCnt = 0;
            modelKnown = 1'b1;
        end else if (fl || h) begin
            if (fl) mFlushCnt++; else mStallCnt++;
        end else begin
            nxt.i = ins; nxt.valid = 1'b1; nxt.chkData = 1'b1;
        end
        sbq.push_back(nxt);
        modelEx   = nxt;
        lastStall = h && rstL;
    endtask

    initial begin : monitor
        exp_t    e;
        tbCtrl_t ac;
        tbData_t ad;
        forever begin
            @(posedge CLK);
            #1;
            if (sbq.size() > 0) begin
                e  = sbq.pop_front();
                ac = {ex_RegDst, ex_ALUSrc, ex_MemToReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
                      ex_Branch, ex_Jump, ex_SignExtend, ex_UseShmt, ex_ALUOp};
                ad = {ex_ReadData1, ex_ReadData2, ex_Imm, ex_PCPlus4, ex_Rs, ex_Rt, ex_Rd, ex_Shamt};
                chk("ex_Valid", ex_Valid, e.valid);
                chk("ex_ctrl", ac, e.i.c);
                if (e.chkData) chk("ex_data", ad, e.i.d);
            end
        end
    end

    initial begin : stimulus
        instr_t ins;
        logic   fl, rs;
        Reset_L = 1'b0; flush = 1'b0; cur = randInstr();

        step(randInstr(), 1'b0, 1'b0, -1);
        step(randInstr(), 1'b1, 1'b0, -1);

        step(mkAdd(3, 1, 2, 32'd5, 32'd7), 0, 1, 0);

        step(mkLw(2, 1), 0, 1, 0);
        step(mkAdd(4, 2, 5, 32'd9, 32'd11), 0, 1, 1);
        step(mkAdd(4, 2, 5, 32'd9, 32'd11), 0, 1, 0);

        step(mkLw(0, 1), 0, 1, 0);
        step(mkAdd(4, 0, 5, 32'd1, 32'd2), 0, 1, 0);
        step(mkLw(2, 1), 0, 1, 0);
        step(mkLui(2), 0, 1, 0);
        step(mkLw(2, 1), 0, 1, 0);
        step(mkSll(4, 2, 3), 0, 1, 1);
        step(mkSll(4, 2, 3), 0, 1, 0);

        step(mkLw(2, 1), 0, 1, 0);
        step(mkAdd(4, 2, 5, 32'd3, 32'd4), 1, 1, 1);
        step(mkAdd(4, 2, 5, 32'd3, 32'd4), 0, 1, 0);

        step(randInstr(), 0, 0, -1);
        for (int k = 0; k < 3; k++) begin
            step(mkLw(2, 1), 0, 1, 0);
            step(mkAdd(4, 2, 5, 32'd1, 32'd1), 0, 1, 1);
            step(mkAdd(4, 2, 5, 32'd1, 32'd1), 0, 1, 0);
        end
        step(mkAdd(6, 7, 8, 32'd1, 32'd1), 1, 1, 0);
        step(mkAdd(6, 7, 8, 32'd1, 32'd1), 1, 1, 0);
        step(mkAdd(6, 7, 8, 32'd1, 32'd1), 0, 1, 0);
`ifdef HAZ_PERF_COUNT_EN
        chk("stall_count_3", stall_count, 32'd3);
        chk("flush_count_2", flush_count, 32'd2);
`endif
        step(randInstr(), 0, 0, -1);
        step(mkAdd(6, 7, 8, 32'd1, 32'd1), 0, 1, 0);
`ifdef HAZ_PERF_COUNT_EN
        chk("stall_count_rst", stall_count, 32'd0);
        chk("flush_count_rst", flush_count, 32'd0);
`endif

        ins = randInstr();
        for (int n = 0; n < 600; n++) begin
            if (!lastStall) ins = randInstr();
            fl = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 59) != 0);
            step(ins, fl, rs, -1);
        end
        step(mkAdd(1, 1, 1, 32'd0, 32'd0), 0, 1, -1);
`ifdef HAZ_PERF_COUNT_EN
        chk("stall_count_model", stall_count, mStallCnt);
        chk("flush_count_model", flush_count, mFlushCnt);
`endif
        step(mkAdd(1, 1, 1, 32'd0, 32'd0), 0, 1, -1);
        @(posedge CLK);
        #2;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
